// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
// Small register bank shared by two requesters (A and B) through a
// round-robin arbiter. Each grant lasts one cycle; the access happens on
// the edge that ends the grant, using the granted requester's
// we/addr/wdata as they stand at that edge. Reads return data one cycle
// later with a single-cycle rvalid pulse tagged by rsel.
//
// Ports
//   clk               : single clock, rising edge
//   rst_n             : asynchronous active-low reset
//   req_a / req_b     : access request
//   we_a / we_b       : 1 = write, 0 = read
//   addr_a / addr_b   : word address (AW bits)
//   wdata_a / wdata_b : write data (DW bits)
//   gnt_a / gnt_b     : grant, Moore outputs, never both high
//   rdata             : read data, holds its value between reads
//   rvalid            : one-cycle pulse marking rdata valid
//   rsel              : owner of rdata (0 = A, 1 = B)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no grant; evaluate requests, round-robin on a tie
// GNT_A | A owns the bank this cycle; access performed at the exit edge
// GNT_B | B owns the bank this cycle; access performed at the exit edge

module reg_bank_arbiter #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          rsel
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t        state, state_nxt;
    // 0 = A was granted last, 1 = B was granted last
    logic          last_grant, last_grant_nxt;

    logic          acc_en;
    logic          acc_sel;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        gnt_a          = 1'b0;
        gnt_b          = 1'b0;
        case (state)
            IDLE: begin
                if (req_a && req_b) begin
                    state_nxt      = last_grant ? GNT_A : GNT_B;
                    last_grant_nxt = ~last_grant;
                end else if (req_a) begin
                    state_nxt      = GNT_A;
                    last_grant_nxt = 1'b0;
                end else if (req_b) begin
                    state_nxt      = GNT_B;
                    last_grant_nxt = 1'b1;
                end
            end
            GNT_A: begin
                gnt_a     = 1'b1;
                state_nxt = IDLE;
            end
            GNT_B: begin
                gnt_b     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Only the granted side's inputs reach the bank.
    always_comb begin
        acc_en    = (state == GNT_A) || (state == GNT_B);
        acc_sel   = (state == GNT_B);
        acc_we    = acc_sel ? we_b    : we_a;
        acc_addr  = acc_sel ? addr_b  : addr_a;
        acc_wdata = acc_sel ? wdata_b : wdata_a;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (acc_en && acc_we) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            rsel   <= 1'b0;
        end else begin
            rvalid <= acc_en && !acc_we;
            if (acc_en && !acc_we) begin
                rdata <= mem[acc_addr];
                rsel  <= acc_sel;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Testbench for reg_bank_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all continuously compared
// against a transaction-level model of the bank and its arbiter.

module tb_reg_bank_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req_a, req_b;
    logic       we_a, we_b;
    logic [1:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       gnt_a, gnt_b;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rsel;

    int n_cmp;
    int n_fail;

    reg_bank_arbiter #(.DW(8), .AW(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_a   (req_a),
        .req_b   (req_b),
        .we_a    (we_a),
        .we_b    (we_b),
        .addr_a  (addr_a),
        .addr_b  (addr_b),
        .wdata_a (wdata_a),
        .wdata_b (wdata_b),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rsel    (rsel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: who holds the bank this cycle (0 none, 1 A, 2 B)
    // last : who was granted most recently (1 A, 2 B)
    int         owner;
    int         last;
    logic [7:0] mm [4];
    logic       m_rvalid;
    logic [7:0] m_rdata;
    logic       m_rsel;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= 0;
            last     <= 2;
            m_rvalid <= 1'b0;
            m_rdata  <= 8'h00;
            m_rsel   <= 1'b0;
            for (int i = 0; i < 4; i++) mm[i] <= 8'h00;
        end else begin
            m_rvalid <= 1'b0;
            if (owner == 1) begin
                if (we_a) mm[addr_a] <= wdata_a;
                else begin
                    m_rvalid <= 1'b1; m_rdata <= mm[addr_a]; m_rsel <= 1'b0;
                end
                owner <= 0;
            end else if (owner == 2) begin
                if (we_b) mm[addr_b] <= wdata_b;
                else begin
                    m_rvalid <= 1'b1; m_rdata <= mm[addr_b]; m_rsel <= 1'b1;
                end
                owner <= 0;
            end else if (req_a && req_b) begin
                owner <= (last == 1) ? 2 : 1;
                last  <= (last == 1) ? 2 : 1;
            end else if (req_a) begin
                owner <= 1; last <= 1;
            end else if (req_b) begin
                owner <= 2; last <= 2;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("gnt_a", gnt_a, owner == 1);
            chk("gnt_b", gnt_b, owner == 2);
            chk("gnt_exclusive", gnt_a & gnt_b, 0);
            chk("rvalid", rvalid, m_rvalid);
            chk("rdata", rdata, m_rdata);
            if (m_rvalid) chk("rsel", rsel, m_rsel);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        req_a = 0; req_b = 0; we_a = 0; we_b = 0;
        addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        chk("rst_gnt_a", gnt_a, 0);
        chk("rst_gnt_b", gnt_b, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rsel", rsel, 0);
        chk("rst_rdata", rdata, 8'h00);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // One access by a single requester; checks grant latency from an idle bank.
    task automatic access(input bit is_b, input logic we, input logic [1:0] addr,
                          input logic [7:0] wd, output logic [7:0] rd, output logic rs);
        int  n;
        bit  got;
        rd = 8'h00; rs = 1'b0; n = 0; got = 0;
        @(negedge clk);
        if (is_b) begin req_b = 1; we_b = we; addr_b = addr; wdata_b = wd; end
        else      begin req_a = 1; we_a = we; addr_a = addr; wdata_a = wd; end
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (is_b ? gnt_b : gnt_a) got = 1;
        end
        chk("grant_seen", got, 1);
        chk("grant_latency", n, 1);
        if (is_b) req_b = 0; else req_a = 0;
        @(negedge clk);
        chk("access_rvalid", rvalid, !we);
        if (!we) begin
            rd = rdata; rs = rsel;
            @(negedge clk);
            chk("rvalid_one_cycle", rvalid, 0);
        end
    endtask

    logic [7:0] rd;
    logic       rs;
    bit         pa, pb;
    bit         da, db;
    int         code;

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single write then read by A
        do_reset();
        access(0, 1, 2'd2, 8'hA5, rd, rs);
        access(0, 0, 2'd2, 8'h00, rd, rs);
        chk("wr_rd_data", rd, 8'hA5);
        chk("wr_rd_rsel", rs, 0);

        // empty read by B after reset
        do_reset();
        access(1, 0, 2'd0, 8'h00, rd, rs);
        chk("empty_rd_data", rd, 8'h00);
        chk("empty_rd_rsel", rs, 1);

        // simultaneous held requests: A, B, A, B every second cycle
        do_reset();
        @(negedge clk);
        req_a = 1; req_b = 1; addr_a = 2'd1; addr_b = 2'd3;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            code = gnt_a ? 1 : (gnt_b ? 2 : 0);
            chk("rr_order", code, (i % 2 == 0) ? 0 : ((i % 4 == 1) ? 1 : 2));
        end
        req_a = 0; req_b = 0;
        repeat (3) @(negedge clk);

        // both write addr 1 together; B is served second so its data remains
        do_reset();
        @(negedge clk);
        req_a = 1; we_a = 1; addr_a = 2'd1; wdata_a = 8'h3C;
        req_b = 1; we_b = 1; addr_b = 2'd1; wdata_b = 8'hC3;
        da = 0; db = 0;
        for (int i = 0; i < 8 && !(da && db); i++) begin
            @(negedge clk);
            if (gnt_a) begin
                chk("isolation_a_first", db, 0);
                da = 1; req_a = 0;
            end
            if (gnt_b) begin db = 1; req_b = 0; end
        end
        chk("isolation_both_granted", da && db, 1);
        @(negedge clk);
        we_a = 0; we_b = 0;
        access(0, 0, 2'd1, 8'h00, rd, rs);
        chk("isolation_rd", rd, 8'hC3);

        // reset during a write grant aborts the write
        do_reset();
        @(negedge clk);
        req_a = 1; we_a = 1; addr_a = 2'd3; wdata_a = 8'hFF;
        @(negedge clk);
        chk("abort_gnt_before", gnt_a, 1);
        #1;
        rst_n = 0; req_a = 0;
        #1;
        chk("abort_gnt_dropped", gnt_a, 0);
        chk("abort_rvalid", rvalid, 0);
        #1;
        rst_n = 1;
        access(0, 0, 2'd3, 8'h00, rd, rs);
        chk("abort_rd", rd, 8'h00);

        // randomized traffic, occasional mid-cycle reset
        do_reset();
        pa = 0; pb = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (pa && gnt_a) begin
                pa = 0; req_a = 0;
            end else if (!pa) begin
                we_a = 1'($urandom); addr_a = 2'($urandom); wdata_a = 8'($urandom);
                if ($urandom_range(0, 2) != 0) begin pa = 1; req_a = 1; end
            end
            if (pb && gnt_b) begin
                pb = 0; req_b = 0;
            end else if (!pb) begin
                we_b = 1'($urandom); addr_b = 2'($urandom); wdata_b = 8'($urandom);
                if ($urandom_range(0, 2) != 0) begin pb = 1; req_b = 1; end
            end
            if ($urandom_range(0, 120) == 0) begin
                #2;
                rst_n = 0; req_a = 0; req_b = 0; pa = 0; pb = 0;
                #1;
                rst_n = 1;
            end
        end
        clear_inputs();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
